// File: rtl/snitch_tcdm_shim.sv
// Snitch data port to TCDM master shim.
// Registers requests and responses (one entry each) and uses a small ID table
// to map the interconnect's meta_id back to the core's request id.
// Payload layouts, MSB first:
//   dreq_i      {addr, write, amo, data, strb, id, lrwait}
//   tcdm_req_o  {tgt_addr, wen, be, data, amo, lrwait, core_id, meta_id}
//   tcdm_resp_i {data, core_id, meta_id}
//   dresp_o     {data, id, lrwait, error}
module snitch_tcdm_shim #(
  parameter int unsigned NumOutstanding = 4,
  parameter int unsigned CoreIdWidth    = 3,
  parameter logic [CoreIdWidth-1:0] CoreId = '0,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned AmoWidth       = 4,
  parameter int unsigned MetaIdWidth    = 4,
  parameter int unsigned TCDMAddrWidth  = 14,
  parameter int unsigned ByteOffset     = 2,
  localparam int unsigned StrbWidth = DataWidth / 8,
  localparam int unsigned DreqWidth = AddrWidth + AmoWidth + DataWidth + StrbWidth + IdWidth + 2,
  localparam int unsigned TreqWidth = TCDMAddrWidth + StrbWidth + DataWidth + AmoWidth
                                      + CoreIdWidth + MetaIdWidth + 2,
  localparam int unsigned TrspWidth = DataWidth + CoreIdWidth + MetaIdWidth,
  localparam int unsigned DrspWidth = DataWidth + IdWidth + 2,
  localparam int unsigned CntWidth  = $clog2(NumOutstanding) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DreqWidth-1:0] dreq_i,
  input  logic                 dreq_valid_i,
  output logic                 dreq_ready_o,
  output logic [TreqWidth-1:0] tcdm_req_o,
  output logic                 tcdm_req_valid_o,
  input  logic                 tcdm_req_ready_i,
  input  logic [TrspWidth-1:0] tcdm_resp_i,
  input  logic                 tcdm_resp_valid_i,
  output logic                 tcdm_resp_ready_o,
  output logic [DrspWidth-1:0] dresp_o,
  output logic                 dresp_valid_o,
  input  logic                 dresp_ready_i,
  output logic [CntWidth-1:0]  outstanding_o
);

  localparam int unsigned IdxWidth = $clog2(NumOutstanding);

  // Request fields
  logic [AddrWidth-1:0] d_addr;
  logic                 d_write;
  logic [AmoWidth-1:0]  d_amo;
  logic [DataWidth-1:0] d_data;
  logic [StrbWidth-1:0] d_strb;
  logic [IdWidth-1:0]   d_id;
  logic                 d_lrwait;
  assign {d_addr, d_write, d_amo, d_data, d_strb, d_id, d_lrwait} = dreq_i;

  // Response fields; the echoed core_id carries no information for this shim
  logic [DataWidth-1:0]   r_data;
  logic [CoreIdWidth-1:0] r_core;
  logic [MetaIdWidth-1:0] r_meta;
  assign {r_data, r_core, r_meta} = tcdm_resp_i;

  logic unused_bits;
  assign unused_bits = ^{d_addr, r_core};

  // ID table
  logic [NumOutstanding-1:0]              slot_vld_q, slot_vld_d;
  logic [NumOutstanding-1:0][IdWidth-1:0] slot_id_q, slot_id_d;
  logic [NumOutstanding-1:0]              slot_lr_q, slot_lr_d;

  // Request / response registers
  logic                 req_vld_q, req_vld_d;
  logic [TreqWidth-1:0] req_q, req_d;
  logic                 rsp_vld_q, rsp_vld_d;
  logic [DrspWidth-1:0] rsp_q, rsp_d;
  logic [IdxWidth-1:0]  rsp_idx_q, rsp_idx_d;
  logic                 rsp_hit_q, rsp_hit_d;

  logic                   expecting, free_any, dreq_xfer, alloc_en, free_en, rsp_xfer;
  logic [IdxWidth-1:0]    alloc_idx, r_idx;
  logic                   r_in_range, r_hit;
  logic [MetaIdWidth-1:0] req_meta;
  logic [CntWidth-1:0]    cnt;

  assign expecting = !d_write || (d_amo != '0);

  // Lowest-index free slot; only registered validity counts, so a slot freed
  // this cycle becomes allocatable next cycle
  always_comb begin
    free_any  = 1'b0;
    alloc_idx = '0;
    for (int i = NumOutstanding - 1; i >= 0; i--) begin
      if (!slot_vld_q[i]) begin
        free_any  = 1'b1;
        alloc_idx = IdxWidth'(i);
      end
    end
  end

  assign dreq_ready_o = (!req_vld_q || tcdm_req_ready_i) && (!expecting || free_any);
  assign dreq_xfer    = dreq_valid_i && dreq_ready_o;
  assign alloc_en     = dreq_xfer && expecting;
  assign req_meta     = alloc_en ? MetaIdWidth'(alloc_idx) : '0;

  // A slot is released when the core accepts the response that hit it
  assign free_en = dresp_valid_o && dresp_ready_i && rsp_hit_q;

  assign tcdm_resp_ready_o = !rsp_vld_q || dresp_ready_i;
  assign rsp_xfer          = tcdm_resp_valid_i && tcdm_resp_ready_o;
  assign r_in_range        = 32'(r_meta) < NumOutstanding;
  assign r_idx             = r_meta[IdxWidth-1:0];
  assign r_hit = r_in_range && slot_vld_q[r_idx] && !(free_en && (rsp_idx_q == r_idx));

  // Count of occupied slots
  always_comb begin
    cnt = '0;
    for (int i = 0; i < NumOutstanding; i++) cnt = cnt + CntWidth'(slot_vld_q[i]);
  end
  assign outstanding_o = cnt;

  // ID table next state: free and allocate never hit the same slot
  always_comb begin
    slot_vld_d = slot_vld_q;
    slot_id_d  = slot_id_q;
    slot_lr_d  = slot_lr_q;
    if (free_en) slot_vld_d[rsp_idx_q] = 1'b0;
    if (alloc_en) begin
      slot_vld_d[alloc_idx] = 1'b1;
      slot_id_d[alloc_idx]  = d_id;
      slot_lr_d[alloc_idx]  = d_lrwait;
    end
  end

  // Request register: load on accept, drop once the interconnect takes it
  always_comb begin
    req_vld_d = req_vld_q && !tcdm_req_ready_i;
    req_d     = req_q;
    if (dreq_xfer) begin
      req_vld_d = 1'b1;
      req_d     = {d_addr[ByteOffset +: TCDMAddrWidth], d_write, d_strb, d_data, d_amo,
                   d_lrwait, CoreId, req_meta};
    end
  end

  // Response register: table lookup happens on capture
  always_comb begin
    rsp_vld_d = rsp_vld_q && !dresp_ready_i;
    rsp_d     = rsp_q;
    rsp_idx_d = rsp_idx_q;
    rsp_hit_d = rsp_hit_q;
    if (rsp_xfer) begin
      rsp_vld_d = 1'b1;
      rsp_idx_d = r_idx;
      rsp_hit_d = r_hit;
      if (r_hit) rsp_d = {r_data, slot_id_q[r_idx], slot_lr_q[r_idx], 1'b0};
      else       rsp_d = {r_data, {IdWidth{1'b0}}, 1'b0, 1'b1};
    end
  end

  // State registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_vld_q <= '0;
      slot_id_q  <= '0;
      slot_lr_q  <= '0;
      req_vld_q  <= 1'b0;
      req_q      <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_q      <= '0;
      rsp_idx_q  <= '0;
      rsp_hit_q  <= 1'b0;
    end else begin
      slot_vld_q <= slot_vld_d;
      slot_id_q  <= slot_id_d;
      slot_lr_q  <= slot_lr_d;
      req_vld_q  <= req_vld_d;
      req_q      <= req_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_q      <= rsp_d;
      rsp_idx_q  <= rsp_idx_d;
      rsp_hit_q  <= rsp_hit_d;
    end
  end

  assign tcdm_req_o       = req_q;
  assign tcdm_req_valid_o = req_vld_q;
  assign dresp_o          = rsp_q;
  assign dresp_valid_o    = rsp_vld_q;

endmodule

// File: tb/tb_snitch_tcdm_shim.sv
// Bench for snitch_tcdm_shim: directed scenarios plus a randomized run
// checked against a transaction-level model of the ID table and channels.
module tb_snitch_tcdm_shim;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [78:0] dreq_i;
  logic        dreq_valid_i, dreq_ready_o;
  logic [62:0] tcdm_req_o;
  logic        tcdm_req_valid_o, tcdm_req_ready_i;
  logic [38:0] tcdm_resp_i;
  logic        tcdm_resp_valid_i, tcdm_resp_ready_o;
  logic [38:0] dresp_o;
  logic        dresp_valid_o, dresp_ready_i;
  logic [2:0]  outstanding_o;

  int total = 0;
  int bad   = 0;

  snitch_tcdm_shim #(.NumOutstanding(4), .CoreId(3'd2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .dreq_i(dreq_i), .dreq_valid_i(dreq_valid_i), .dreq_ready_o(dreq_ready_o),
    .tcdm_req_o(tcdm_req_o), .tcdm_req_valid_o(tcdm_req_valid_o), .tcdm_req_ready_i(tcdm_req_ready_i),
    .tcdm_resp_i(tcdm_resp_i), .tcdm_resp_valid_i(tcdm_resp_valid_i), .tcdm_resp_ready_o(tcdm_resp_ready_o),
    .dresp_o(dresp_o), .dresp_valid_o(dresp_valid_o), .dresp_ready_i(dresp_ready_i),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  // field views
  logic [31:0] q_addr, q_data; logic q_w, q_lr; logic [3:0] q_amo, q_strb; logic [4:0] q_id;
  assign {q_addr, q_w, q_amo, q_data, q_strb, q_id, q_lr} = dreq_i;
  logic [13:0] t_addr; logic t_wen, t_lr; logic [3:0] t_be, t_amo, t_meta; logic [31:0] t_data; logic [2:0] t_core;
  assign {t_addr, t_wen, t_be, t_data, t_amo, t_lr, t_core, t_meta} = tcdm_req_o;
  logic [31:0] r_data; logic [4:0] r_id; logic r_lr, r_err;
  assign {r_data, r_id, r_lr, r_err} = dresp_o;

  function automatic logic [78:0] mk_dreq(input logic [31:0] a, input logic w, input logic [3:0] amo,
                                          input logic [31:0] d, input logic [4:0] id);
    return {a, w, amo, d, 4'hf, id, 1'b0};
  endfunction

  function automatic logic [38:0] mk_resp(input logic [31:0] d, input logic [3:0] meta);
    return {d, 3'd2, meta};
  endfunction

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // drive one core request until accepted (bounded); returns at edge+1 after transfer
  task automatic put_dreq(input logic [78:0] v, output bit ok);
    dreq_i = v; dreq_valid_i = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1; ok = dreq_ready_o;
      @(posedge clk_i); #1;
    end
    dreq_valid_i = 1'b0;
  endtask

  task automatic put_resp(input logic [38:0] v, output bit ok);
    tcdm_resp_i = v; tcdm_resp_valid_i = 1'b1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1; ok = tcdm_resp_ready_o;
      @(posedge clk_i); #1;
    end
    tcdm_resp_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; dreq_i = '0; dreq_valid_i = 0; tcdm_req_ready_i = 1; tcdm_resp_i = '0;
    tcdm_resp_valid_i = 0; dresp_ready_i = 1;
    #12;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL reset_out got %0d want 0", outstanding_o); end
    total++; if (tcdm_req_valid_o !== 1'b0) begin bad++; $display("FAIL reset_reqv got %b want 0", tcdm_req_valid_o); end
    total++; if (dresp_valid_o !== 1'b0) begin bad++; $display("FAIL reset_rspv got %b want 0", dresp_valid_o); end
    total++; if (dreq_ready_o !== 1'b1) begin bad++; $display("FAIL reset_dready got %b want 1", dreq_ready_o); end
    total++; if (tcdm_resp_ready_o !== 1'b1) begin bad++; $display("FAIL reset_rready got %b want 1", tcdm_resp_ready_o); end
    total++; if (tcdm_req_o !== 63'd0 || dresp_o !== 39'd0) begin bad++; $display("FAIL reset_payload got %h/%h want 0", tcdm_req_o, dresp_o); end
    @(posedge clk_i); #1; rst_i = 1'b0; tick();
  endtask

  task automatic test_load();
    bit ok;
    put_dreq(mk_dreq(32'h0000_0104, 0, 0, 32'h0, 5'd5), ok);
    total++; if (!ok || tcdm_req_valid_o !== 1'b1) begin bad++; $display("FAIL load_issue ok=%b v=%b want 1", ok, tcdm_req_valid_o); end
    total++; if ({t_addr, t_wen, t_core, t_meta} !== {14'h41, 1'b0, 3'd2, 4'd0})
      begin bad++; $display("FAIL load_map got %h %b %0d %0d want 41 0 2 0", t_addr, t_wen, t_core, t_meta); end
    total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL load_out got %0d want 1", outstanding_o); end
    put_resp(mk_resp(32'hDEAD_BEEF, 4'd0), ok);
    total++; if (!ok || dresp_valid_o !== 1'b1 || {r_data, r_id, r_err} !== {32'hDEAD_BEEF, 5'd5, 1'b0})
      begin bad++; $display("FAIL load_resp got v=%b %h id %0d err %b want DEADBEEF 5 0", dresp_valid_o, r_data, r_id, r_err); end
    tick();
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL load_free got %0d want 0", outstanding_o); end
  endtask

  task automatic test_full();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      put_dreq(mk_dreq(32'h100 + 32'(i * 4), 0, 0, 0, 5'(i + 1)), ok);
      total++; if (!ok || t_meta !== 4'(i)) begin bad++; $display("FAIL full_meta%0d got %0d want %0d", i, t_meta, i); end
    end
    total++; if (outstanding_o !== 3'd4) begin bad++; $display("FAIL full_out got %0d want 4", outstanding_o); end
    dreq_i = mk_dreq(32'h200, 0, 0, 0, 5'd6); dreq_valid_i = 1'b1; #1;
    total++; if (dreq_ready_o !== 1'b0) begin bad++; $display("FAIL full_block got %b want 0", dreq_ready_o); end
    @(posedge clk_i); #1; dreq_valid_i = 1'b0; tick();
    put_dreq(mk_dreq(32'h300, 1, 0, 32'h1234, 5'd7), ok);
    total++; if (!ok || {t_wen, t_meta} !== {1'b1, 4'd0} || outstanding_o !== 3'd4)
      begin bad++; $display("FAIL full_store ok=%b wen=%b meta=%0d out=%0d want 1 1 0 4", ok, t_wen, t_meta, outstanding_o); end
  endtask

  task automatic test_free_alloc();
    bit ok;
    put_resp(mk_resp(32'h22, 4'd2), ok);
    total++; if (!ok || r_id !== 5'd3 || r_err !== 1'b0) begin bad++; $display("FAIL fa_resp got id %0d err %b want 3 0", r_id, r_err); end
    dreq_i = mk_dreq(32'h400, 0, 0, 0, 5'd9); dreq_valid_i = 1'b1; #1;
    total++; if (dreq_ready_o !== 1'b0 || outstanding_o !== 3'd4)
      begin bad++; $display("FAIL fa_same got rdy %b out %0d want 0 4", dreq_ready_o, outstanding_o); end
    @(posedge clk_i); #1;
    total++; if (outstanding_o !== 3'd3) begin bad++; $display("FAIL fa_freed got %0d want 3", outstanding_o); end
    #1;
    total++; if (dreq_ready_o !== 1'b1) begin bad++; $display("FAIL fa_rdy got %b want 1", dreq_ready_o); end
    @(posedge clk_i); #1; dreq_valid_i = 1'b0;
    total++; if (tcdm_req_valid_o !== 1'b1 || t_meta !== 4'd2 || outstanding_o !== 3'd4)
      begin bad++; $display("FAIL fa_realloc got v %b meta %0d out %0d want 1 2 4", tcdm_req_valid_o, t_meta, outstanding_o); end
    put_resp(mk_resp(32'h0, 4'd0), ok);
    total++; if (r_id !== 5'd1) begin bad++; $display("FAIL fa_d0 got %0d want 1", r_id); end
    put_resp(mk_resp(32'h0, 4'd1), ok);
    total++; if (r_id !== 5'd2) begin bad++; $display("FAIL fa_d1 got %0d want 2", r_id); end
    put_resp(mk_resp(32'h0, 4'd3), ok);
    total++; if (r_id !== 5'd4) begin bad++; $display("FAIL fa_d3 got %0d want 4", r_id); end
    put_resp(mk_resp(32'h0, 4'd2), ok);
    total++; if (r_id !== 5'd9 || r_err !== 1'b0) begin bad++; $display("FAIL fa_d2 got %0d err %b want 9 0", r_id, r_err); end
    tick();
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL fa_empty got %0d want 0", outstanding_o); end
  endtask

  task automatic test_simul();
    bit ok;
    put_dreq(mk_dreq(32'h500, 0, 0, 0, 5'd11), ok);
    put_resp(mk_resp(32'h5, 4'd0), ok);
    dreq_i = mk_dreq(32'h504, 0, 0, 0, 5'd12); dreq_valid_i = 1'b1; #1;
    total++; if (dreq_ready_o !== 1'b1) begin bad++; $display("FAIL sim_rdy got %b want 1", dreq_ready_o); end
    @(posedge clk_i); #1; dreq_valid_i = 1'b0;
    total++; if (outstanding_o !== 3'd1 || t_meta !== 4'd1)
      begin bad++; $display("FAIL sim_out got out %0d meta %0d want 1 1", outstanding_o, t_meta); end
    put_resp(mk_resp(32'h6, 4'd1), ok);
    total++; if (r_id !== 5'd12) begin bad++; $display("FAIL sim_id got %0d want 12", r_id); end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [62:0] exp;
    tcdm_req_ready_i = 1'b0;
    put_dreq(mk_dreq(32'h0000_2a0c, 0, 0, 32'hcafe, 5'd13), ok);
    exp = {14'h0a83, 1'b0, 4'hf, 32'hcafe, 4'h0, 1'b0, 3'd2, 4'd0};
    dreq_i = mk_dreq(32'h600, 0, 0, 0, 5'd14); dreq_valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++; if (tcdm_req_valid_o !== 1'b1 || tcdm_req_o !== exp || dreq_ready_o !== 1'b0)
        begin bad++; $display("FAIL bp_hold%0d got v %b %h rdy %b want 1 %h 0", k, tcdm_req_valid_o, tcdm_req_o, dreq_ready_o, exp); end
      @(posedge clk_i); #1;
    end
    dreq_valid_i = 1'b0; tcdm_req_ready_i = 1'b1; tick();
    total++; if (tcdm_req_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain got %b want 0", tcdm_req_valid_o); end
    put_resp(mk_resp(32'h0, 4'd0), ok); tick();
  endtask

  task automatic test_bad_meta();
    bit ok;
    put_dreq(mk_dreq(32'h700, 0, 0, 0, 5'd14), ok);
    put_resp(mk_resp(32'h66, 4'd6), ok);
    total++; if (r_err !== 1'b1 || r_id !== 5'd0 || outstanding_o !== 3'd1)
      begin bad++; $display("FAIL bad_range got err %b id %0d out %0d want 1 0 1", r_err, r_id, outstanding_o); end
    put_resp(mk_resp(32'h77, 4'd2), ok);
    total++; if (r_err !== 1'b1 || outstanding_o !== 3'd1)
      begin bad++; $display("FAIL bad_unalloc got err %b out %0d want 1 1", r_err, outstanding_o); end
    tick();
    total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL bad_keep got %0d want 1", outstanding_o); end
    put_resp(mk_resp(32'h88, 4'd0), ok);
    total++; if (r_err !== 1'b0 || r_id !== 5'd14) begin bad++; $display("FAIL bad_good got err %b id %0d want 0 14", r_err, r_id); end
    tick();
  endtask

  task automatic test_reset_inflight();
    bit ok;
    put_dreq(mk_dreq(32'h800, 0, 0, 0, 5'd20), ok);
    put_dreq(mk_dreq(32'h804, 0, 0, 0, 5'd21), ok);
    dresp_ready_i = 1'b0;
    put_resp(mk_resp(32'h1, 4'd0), ok);
    tcdm_req_ready_i = 1'b0;
    put_dreq(mk_dreq(32'h808, 1, 0, 32'h99, 5'd22), ok);
    rst_i = 1'b1; #1;
    total++; if ({tcdm_req_valid_o, dresp_valid_o, dreq_ready_o, tcdm_resp_ready_o} !== 4'b0011 || outstanding_o !== 3'd0)
      begin bad++; $display("FAIL rst_fly got %b%b%b%b out %0d want 0011 0", tcdm_req_valid_o, dresp_valid_o, dreq_ready_o, tcdm_resp_ready_o, outstanding_o); end
    total++; if (tcdm_req_o !== 63'd0 || dresp_o !== 39'd0) begin bad++; $display("FAIL rst_fly_pay got %h %h want 0", tcdm_req_o, dresp_o); end
    @(posedge clk_i); #1; rst_i = 1'b0; tcdm_req_ready_i = 1'b1; dresp_ready_i = 1'b1;
    put_resp(mk_resp(32'h2, 4'd1), ok);
    total++; if (r_err !== 1'b1 || r_id !== 5'd0) begin bad++; $display("FAIL rst_late got err %b id %0d want 1 0", r_err, r_id); end
    tick();
  endtask

  task automatic test_random();
    bit mv[4]; logic [4:0] mid[4]; logic mlr[4];
    logic [62:0] eq[$]; bit eq_x[$];
    logic [38:0] er[$]; int er_slot[$];
    logic [3:0] pend[$];
    bit dx, tx, rx, ox, e_drdy, e_rrdy, expct;
    int cnt, slot, fslot, k;
    logic [3:0] m;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!dreq_valid_i && cyc < 2600 && $urandom_range(0, 2) != 0) begin
        dreq_i = {32'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0,
                  32'($urandom), 4'($urandom), 5'($urandom), 1'($urandom)};
        dreq_valid_i = 1'b1;
      end
      tcdm_req_ready_i = ($urandom_range(0, 3) != 0);
      if (!tcdm_resp_valid_i && $urandom_range(0, 1) == 0) begin
        if (pend.size() != 0) begin
          k = $urandom_range(0, pend.size() - 1);
          tcdm_resp_i = {32'($urandom), 3'd2, pend[k]}; pend.delete(k); tcdm_resp_valid_i = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          tcdm_resp_i = {32'($urandom), 3'd2, 4'($urandom_range(4, 15))}; tcdm_resp_valid_i = 1'b1;
        end
      end
      dresp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      expct = !q_w || (q_amo != 4'd0);
      cnt = 0; slot = -1;
      for (int i = 3; i >= 0; i--) begin
        if (mv[i]) cnt++; else slot = i;
      end
      e_drdy = (eq.size() == 0 || tcdm_req_ready_i) && (!expct || slot >= 0);
      e_rrdy = (er.size() == 0) || dresp_ready_i;
      total++; if (dreq_ready_o !== e_drdy) begin bad++; $display("FAIL rnd_drdy c%0d got %b want %b", cyc, dreq_ready_o, e_drdy); end
      total++; if (tcdm_req_valid_o !== (eq.size() != 0) || (eq.size() != 0 && tcdm_req_o !== eq[0]))
        begin bad++; $display("FAIL rnd_req c%0d got %b %h want %0d %h", cyc, tcdm_req_valid_o, tcdm_req_o, eq.size(), (eq.size() != 0) ? eq[0] : 63'd0); end
      total++; if (dresp_valid_o !== (er.size() != 0) || (er.size() != 0 && dresp_o !== er[0]))
        begin bad++; $display("FAIL rnd_rsp c%0d got %b %h want %0d %h", cyc, dresp_valid_o, dresp_o, er.size(), (er.size() != 0) ? er[0] : 39'd0); end
      total++; if (tcdm_resp_ready_o !== e_rrdy) begin bad++; $display("FAIL rnd_rrdy c%0d got %b want %b", cyc, tcdm_resp_ready_o, e_rrdy); end
      total++; if (outstanding_o !== 3'(cnt)) begin bad++; $display("FAIL rnd_out c%0d got %0d want %0d", cyc, outstanding_o, cnt); end
      dx = dreq_valid_i && e_drdy; tx = (eq.size() != 0) && tcdm_req_ready_i;
      rx = tcdm_resp_valid_i && e_rrdy; ox = (er.size() != 0) && dresp_ready_i;
      fslot = -1;
      if (ox) begin fslot = er_slot[0]; void'(er.pop_front()); void'(er_slot.pop_front()); end
      if (rx) begin
        m = tcdm_resp_i[3:0];
        if (m < 4 && mv[m[1:0]]) begin er.push_back({tcdm_resp_i[38:7], mid[m[1:0]], mlr[m[1:0]], 1'b0}); er_slot.push_back(int'(m)); end
        else begin er.push_back({tcdm_resp_i[38:7], 5'd0, 1'b0, 1'b1}); er_slot.push_back(-1); end
      end
      if (fslot >= 0) mv[fslot] = 1'b0;
      if (tx) begin
        if (eq_x[0]) pend.push_back(eq[0][3:0]);
        void'(eq.pop_front()); void'(eq_x.pop_front());
      end
      if (dx) begin
        eq.push_back({q_addr[15:2], q_w, q_strb, q_data, q_amo, q_lr, 3'd2, expct ? 4'(slot) : 4'd0});
        eq_x.push_back(expct);
        if (expct) begin mv[slot] = 1'b1; mid[slot] = q_id; mlr[slot] = q_lr; end
      end
      @(posedge clk_i); #1;
      if (dx) dreq_valid_i = 1'b0;
      if (rx) tcdm_resp_valid_i = 1'b0;
    end
    total++; if (outstanding_o !== 3'd0 || pend.size() != 0)
      begin bad++; $display("FAIL rnd_drain got out %0d pend %0d want 0 0", outstanding_o, pend.size()); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_full();
    test_free_alloc();
    test_simul();
    test_backpressure();
    test_bad_meta();
    test_reset_inflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
